qe_mac_param: RTL
=================

Name: qe_mac_param

Overview:
Parametrised successor to the fixed 8-bit quadratic/MAC unit. The block is a two-stage pipelined arithmetic engine with two modes:
- mode 0: evaluates a*x^2 + b*x + c for every valid sample.
- mode 1: accumulates a*x products over a packet terminated by last_input.
It adds configurable data/result width, selectable wrap or saturation, an overflow flag, and defined packet-abort rules. It sits in the datapath between the operand sequencer and the result collector.

Parameters:
- DW, 8: operand width (in_a, in_b, in_c, in_x), unsigned.
- RW, 16: result width; must satisfy RW >= 2*DW.
- SAT, 0: 0 = results wrap modulo 2^RW; 1 = results clamp to 2^RW-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_a  in  DW  coefficient a (mode 0) / multiplicand (mode 1).
- in_b  in  DW  coefficient b (mode 0 only).
- in_c  in  DW  coefficient c (mode 0 only).
- in_x  in  DW  variable x (mode 0) / multiplier (mode 1).
- mode  in  1  0 = quadratic, 1 = MAC; sampled with valid_in.
- valid_in  in  1  inputs are valid this cycle.
- last_input  in  1  final beat of a MAC packet; honoured only when valid_in=1 and mode=1.
- valid_out  out  1  result is a completed quadratic or completed MAC packet.
- result  out  RW  output value.
- overflow  out  1  full-precision value exceeded 2^RW-1; qualifies result.

Behaviour:
- Reset (asynchronous, active-high): all pipeline registers, accumulator, valid_out, result and overflow go to 0. Reset asserted mid-operation drops in-flight beats and any partial accumulation.
- Arithmetic is unsigned. Internal full-precision width is 3*DW+2 bits; no truncation happens before the final RW stage.
- Stage 1 (edge N, valid_in=1): registers x*x, b*x, a*x, a, c, mode, last and a valid bit.
- Stage 2 (edge N+1):
  - mode 0: computes a*(x*x) + b*x + c.
  - mode 1: computes acc + a*x.
  - result, valid_out and overflow update at edge N+1. Latency is fixed at 2 edges from sample to output, with throughput of 1 beat per cycle.
- Invalid beats (valid_in=0) propagate as bubbles. result, overflow and accumulator hold. valid_out=0.
- result updates on every valid stage-2 beat:
  - mode 0: the quadratic value.
  - mode 1: the running accumulator, visible but not valid.
- valid_out=1 for one cycle per mode-0 valid beat, and for a mode-1 valid beat carrying last. Otherwise valid_out=0.
- Wrap/saturate:
  - SAT=0: result = full value mod 2^RW.
  - SAT=1: result = 2^RW-1 whenever full value > 2^RW-1.
- overflow:
  - mode 0: set per beat.
  - mode 1: sticky across the packet, so once set it stays 1 until the packet ends.
  - With SAT=1 the accumulator stays clamped for the rest of the packet.
- Accumulator state machine:
  - IDLE (acc=0) goes to ACC on a mode-1 valid beat without last.
  - ACC goes back to IDLE on a mode-1 valid beat with last. acc clears after that output, so the next packet starts from 0.
  - A mode-1 valid beat with last while in IDLE is a single-beat packet: result = a*x, valid_out=1.
  - A mode-0 valid beat while in ACC aborts the packet: acc and sticky overflow clear, state goes to IDLE, and the quadratic result is output normally.
- last_input with valid_in=0 is ignored. last_input in mode 0 is ignored.
- Back-to-back beats of mixed modes are legal with no bubbles required.

Test Plan:
- Quadratic, DW=8/RW=16/SAT=0: a=3, b=5, c=7, x=10 on one valid cycle → 2 edges later result=357, valid_out=1 for 1 cycle, overflow=0.
- Overflow: a=255, b=0, c=0, x=255:
  - SAT=0 → result=767 (0xFD02FF mod 2^16), overflow=1.
  - Rerun with SAT=1 → result=65535, overflow=1.
- MAC packet: beats (a=20, x=40, last=0), an invalid beat, then (a=1, x=2, last=1):
  - result goes 800 (valid_out=0), holds 800 (valid_out=0), then 802 (valid_out=1).
  - A following single beat (a=3, x=3, last=1) → result=9, valid_out=1.
- Abort: MAC beat (a=20, x=40, last=0), then mode-0 beat (a=1, b=1, c=1, x=1), then MAC beat (a=2, x=2, last=1) → results 800/inv, 3/valid, 4/valid.
- Reset mid-op: assert reset one cycle after a valid quadratic beat → valid_out, result and overflow go to 0 immediately, and no output emerges for the dropped beat.
- Throughput: 4 consecutive mode-0 beats with x=0..3, a=b=c=1 → valid_out high 4 consecutive cycles with results 1, 3, 7, 13.

Source files
------------

// File: rtl/qe_mac_param_if.sv
// Operand/result bus between the operand sequencer and the quadratic/MAC engine.
// The sequencer drives operands as master; the engine returns results as slave.
interface qe_mac_param_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 16
);
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] in_c;
    logic [DW-1:0] in_x;
    logic          mode;
    logic          valid_in;
    logic          last_input;
    logic          valid_out;
    logic [RW-1:0] result;
    logic          overflow;

    modport master (
        output in_a, in_b, in_c, in_x, mode, valid_in, last_input,
        input  valid_out, result, overflow
    );

    modport slave (
        input  in_a, in_b, in_c, in_x, mode, valid_in, last_input,
        output valid_out, result, overflow
    );
endinterface

// File: rtl/qe_mac_param.sv
// Two-stage unsigned engine: mode 0 evaluates a*x^2 + b*x + c per beat, mode 1
// accumulates a*x over a packet closed by last_input. Optional saturation at RW bits.
module qe_mac_param #(
    parameter int unsigned DW  = 8,
    parameter int unsigned RW  = 16,
    parameter bit          SAT = 1'b0
) (
    input logic           clk,
    input logic           reset,
    qe_mac_param_if.slave bus
);
    localparam int unsigned FW = 3 * DW + 2;
    // Sum width must also hold acc + a*x when RW exceeds the full-precision width.
    localparam int unsigned SW = (RW + 1 > FW) ? RW + 1 : FW;

    typedef enum logic {StIdle, StAcc} state_e;

    logic [2*DW-1:0] a_w, b_w, x_w;
    logic [2*DW-1:0] xx_d, bx_d, ax_d;

    logic [2*DW-1:0] xx_q, bx_q, ax_q;
    logic [DW-1:0]   a_q, c_q;
    logic            mode_q, last_q, vld_q;

    state_e          state_q, state_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic            sticky_q, sticky_d;
    logic [RW-1:0]   result_q, result_d;
    logic            overflow_q, overflow_d;
    logic            valid_out_q, valid_out_d;

    logic [SW-1:0]   quad_full, mac_full, full;
    logic [RW-1:0]   acc_base, val;
    logic            ovf_beat;

    assign a_w  = {{DW{1'b0}}, bus.in_a};
    assign b_w  = {{DW{1'b0}}, bus.in_b};
    assign x_w  = {{DW{1'b0}}, bus.in_x};
    assign xx_d = x_w * x_w;
    assign bx_d = b_w * x_w;
    assign ax_d = a_w * x_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xx_q   <= '0;
            bx_q   <= '0;
            ax_q   <= '0;
            a_q    <= '0;
            c_q    <= '0;
            mode_q <= 1'b0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= bus.valid_in;
            if (bus.valid_in) begin
                xx_q   <= xx_d;
                bx_q   <= bx_d;
                ax_q   <= ax_d;
                a_q    <= bus.in_a;
                c_q    <= bus.in_c;
                mode_q <= bus.mode;
                last_q <= bus.last_input & bus.mode;
            end
        end
    end

    assign acc_base  = (state_q == StAcc) ? acc_q : '0;
    assign quad_full = SW'(a_q) * SW'(xx_q) + SW'(bx_q) + SW'(c_q);
    assign mac_full  = SW'(acc_base) + SW'(ax_q);
    assign full      = mode_q ? mac_full : quad_full;
    assign ovf_beat  = |full[SW-1:RW];
    assign val       = (SAT && ovf_beat) ? '1 : full[RW-1:0];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        valid_out_d = 1'b0;
        if (vld_q) begin
            result_d = val;
            if (!mode_q) begin
                // A quadratic beat also aborts any open packet.
                overflow_d  = ovf_beat;
                valid_out_d = 1'b1;
                acc_d       = '0;
                sticky_d    = 1'b0;
                state_d     = StIdle;
            end else begin
                overflow_d = sticky_q | ovf_beat;
                if (last_q) begin
                    valid_out_d = 1'b1;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                    state_d     = StIdle;
                end else begin
                    acc_d    = val;
                    sticky_d = sticky_q | ovf_beat;
                    state_d  = StAcc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.valid_out = valid_out_q;
endmodule
